// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI master types and constants
package spi_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int BITS = 8;
  localparam int HALVES = 16;
  localparam logic IDLE_MOSI = 1'b1;
endpackage

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 byte master with software chip select
module spi_master
  import spi_pkg::*;
#(
  parameter logic CSRST = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ce,
  input  logic            tx,
  input  logic            rx,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q,
  output logic            busy,
  input  logic            csWr,
  input  logic            csD,
  output logic            cs,
  output logic            ck,
  output logic            mosi,
  input  logic            miso
);
  state_t          state;
  logic [3:0]      cnt;
  logic [BITS-1:0] sr;
  logic            bit_hold;
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '1;
      bit_hold <= 1'b1;
      ck       <= 1'b0;
      mosi     <= IDLE_MOSI;
      busy     <= 1'b0;
      q        <= '1;
      cs       <= CSRST;
    end else begin
      if (csWr) cs <= csD;
      if (state == IDLE) begin
        if (tx || rx) begin
          sr    <= tx ? d : '1;
          mosi  <= tx ? d[BITS-1] : IDLE_MOSI;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
      end else if (ce) begin
        cnt <= cnt + 1'b1;
        if (!cnt[0]) begin
          ck       <= 1'b1;
          bit_hold <= miso;
        end else begin
          ck   <= 1'b0;
          sr   <= {sr[BITS-2:0], bit_hold};
          mosi <= sr[BITS-2];
          if (cnt == 4'(HALVES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            q     <= {sr[BITS-2:0], bit_hold};
            mosi  <= IDLE_MOSI;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed self-checking bench for spi_master
module tb_spi_master;
  logic       clock = 1'b0;
  logic       reset, ce, tx, rx, csWr, csD, miso_drv, loop;
  logic [7:0] d, q, pat;
  logic       busy, cs, ck, mosi, miso;
  int         n_checks = 0;
  int         n_fail = 0;
  int         bcnt, rises, gap;
  logic [7:0] mbits;
  logic       mo_and;
  always #5 clock = ~clock;
  assign miso = loop ? mosi : miso_drv;
  spi_master dut (
    .clock(clock), .reset(reset), .ce(ce), .tx(tx), .rx(rx), .d(d), .q(q),
    .busy(busy), .csWr(csWr), .csD(csD), .cs(cs), .ck(ck), .mosi(mosi), .miso(miso)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic xfer(input logic t, input logic r, input logic [7:0] dv, input int per,
                      input int tx2_at, input logic [7:0] d2);
    int   k, first_rise;
    logic prev_ck;
    bcnt = 0; rises = 0; gap = 0; mbits = '0; mo_and = 1'b1;
    first_rise = -1; prev_ck = 1'b0;
    tx = t; rx = r; d = dv; ce = 1'b1; miso_drv = pat[7];
    step();
    tx = 1'b0; rx = 1'b0;
    for (k = 1; k < 200; k++) begin
      if (busy) begin
        bcnt++;
        mo_and &= mosi;
      end
      if (ck && !prev_ck) begin
        rises++;
        mbits = {mbits[6:0], mosi};
        if (first_rise < 0) first_rise = k;
        else if (rises == 2) gap = k - first_rise;
      end
      prev_ck = ck;
      if (!busy) break;
      miso_drv = rises < 8 ? pat[7-rises] : 1'b0;
      ce = (k % per) == 0;
      tx = k == tx2_at;
      if (k == tx2_at) d = d2;
      step();
    end
    if (k >= 200) check("xfer_timeout", 1, 0);
    tx = 1'b0; ce = 1'b0;
  endtask
  initial begin
    reset = 1'b1; ce = 1'b0; tx = 1'b0; rx = 1'b0; csWr = 1'b0; csD = 1'b1;
    d = '0; loop = 1'b1; miso_drv = 1'b0; pat = 8'h00;
    step(); step();
    check("rst_cs", cs, 1);
    check("rst_ck", ck, 0);
    check("rst_mosi", mosi, 1);
    check("rst_busy", busy, 0);
    check("rst_q", q, 8'hFF);
    reset = 1'b0;
    ce = 1'b1;
    step(); step();
    check("idle_no_start_busy", busy, 0);
    xfer(1, 0, 8'hA5, 1, 16, 8'h00);
    check("lb_busy_cycles", bcnt, 16);
    check("lb_rises", rises, 8);
    check("lb_mosi_bits", mbits, 8'hA5);
    check("lb_q", q, 8'hA5);
    check("lb_end_ck", ck, 0);
    check("lb_end_mosi", mosi, 1);
    step();
    check("start_on_fall_ignored", busy, 0);
    loop = 1'b0; pat = 8'h3C;
    xfer(0, 1, 8'h00, 1, -1, 8'h00);
    check("rx_mosi_high", mo_and, 1);
    check("rx_mosi_bits", mbits, 8'hFF);
    check("rx_q", q, 8'h3C);
    check("rx_busy_cycles", bcnt, 16);
    check("rx_busy_low", busy, 0);
    loop = 1'b1;
    xfer(1, 1, 8'h55, 1, 5, 8'h00);
    check("both_mosi_bits", mbits, 8'h55);
    check("both_q", q, 8'h55);
    check("both_busy_cycles", bcnt, 16);
    xfer(1, 0, 8'hF0, 4, -1, 8'h00);
    check("slow_busy_cycles", bcnt, 64);
    check("slow_ck_period", gap, 8);
    check("slow_q", q, 8'hF0);
    check("slow_rises", rises, 8);
    tx = 1'b1; d = 8'hA5; ce = 1'b1;
    step();
    tx = 1'b0;
    step(); step();
    csWr = 1'b1; csD = 1'b0;
    step();
    csWr = 1'b0;
    check("cs_mid_xfer", cs, 0);
    check("busy_after_cswr", busy, 1);
    repeat (5) step();
    check("q_unchanged_mid", q, 8'hF0);
    reset = 1'b1;
    step();
    reset = 1'b0; ce = 1'b0;
    check("abort_cs", cs, 1);
    check("abort_ck", ck, 0);
    check("abort_mosi", mosi, 1);
    check("abort_busy", busy, 0);
    check("abort_q", q, 8'hFF);
    csWr = 1'b1; csD = 1'b0;
    step();
    csWr = 1'b0; csD = 1'b1;
    check("cs_idle_write", cs, 0);
    step();
    check("cs_hold", cs, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL expose parameter CSRST, default 1'b1, meaning reset (deselected) level of cs.
REQ-002 SHALL expose clock  input  1  system clock; all logic on posedge.
REQ-003 SHALL expose reset  input  1  synchronous, active-high reset.
REQ-004 SHALL expose ce  input  1  clock enable; one ce pulse = one SPI half-bit.
REQ-005 SHALL expose tx  input  1  one-clock strobe: start a transfer sending d.
REQ-006 SHALL expose rx  input  1  one-clock strobe: start a transfer sending 8'hFF.
REQ-007 SHALL expose d  input  8  byte to transmit, sampled with tx.
REQ-008 SHALL expose q  output  8  last received byte.
REQ-009 SHALL expose busy  output  1  high while a transfer is in progress.
REQ-010 SHALL expose csWr  input  1  one-clock strobe: load csD into cs.
REQ-011 SHALL expose csD  input  1  new chip-select level.
REQ-012 SHALL expose cs  output  1  SD chip select, active low.
REQ-013 SHALL expose ck  output  1  SPI clock, mode 0 (idle low).
REQ-014 SHALL expose mosi  output  1  serial data to card, MSB first.
REQ-015 SHALL expose miso  input  1  serial data from card.

Function
REQ-016 SHALL implement states IDLE and SHIFT only.
REQ-017 In IDLE, tx&~busy SHALL load shift register with d, clear the 4-bit half-bit counter and enter SHIFT on the next clock.
REQ-018 In IDLE, rx&~tx SHALL start identically with shift register 8'hFF.
REQ-019 When tx and rx are both asserted, tx SHALL win.
REQ-020 tx, rx asserted while busy SHALL be ignored: no restart, no queueing, d not sampled.
REQ-021 busy SHALL be high from the clock after the start strobe until the clock in which the 16th ce of the transfer is consumed, inclusive.
REQ-022 mosi SHALL present shift-register bit 7 from the clock after start and stay stable through each high phase of ck.
REQ-023 On even-count ce in SHIFT, ck SHALL go high and miso SHALL be sampled into a bit holder.
REQ-024 On odd-count ce, ck SHALL go low and the shift register SHALL shift left with the sampled miso bit entering bit 0.
REQ-025 After the 16th ce (counter wrap 15->0), q SHALL hold the 8 received bits, busy SHALL fall, ck SHALL be low and the state SHALL return to IDLE.
REQ-026 Transfer latency SHALL be exactly 16 ce pulses; clocks without ce SHALL freeze all SHIFT state.
REQ-027 In IDLE, mosi SHALL be 1 and ck SHALL be 0.
REQ-028 q SHALL change only at transfer completion.
REQ-029 csWr SHALL update cs on the next clock in any state, including mid-transfer; the transfer SHALL continue unaffected.
REQ-030 A new start in the same clock busy falls SHALL be ignored; starts are accepted from the following clock.

Reset
REQ-031 reset SHALL force state IDLE, counter 0, ck 0, mosi 1, busy 0, q 8'hFF, cs CSRST.
REQ-032 reset during SHIFT SHALL abort the transfer with no update of q other than the reset value.
REQ-033 reset SHALL take priority over tx, rx, csWr and ce.

Structure
REQ-034 The state enum and the constants BITS=8, HALVES=16 and IDLE_MOSI=1 SHALL live in the shared package spi_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; ce generation is the instantiator's responsibility.

Verification
REQ-036 Loopback (miso=mosi), d=8'hA5, tx, ce every clock -> busy for 16 clocks, 8 ck rising edges, mosi 1,0,1,0,0,1,0,1, q=8'hA5.
REQ-037 rx with miso driven 8'h3C MSB-first on rising ck -> mosi held 1 throughout, q=8'h3C, busy low after 16th ce.
REQ-038 tx (d=8'h55) and rx in the same clock, then tx (d=8'h00) at transfer clock 5 -> transfer sends 8'h55 only, second strobe ignored.
REQ-039 ce every 4th clock, d=8'hF0 -> busy for 64 clocks, ck period 8 clocks, q equals loopback 8'hF0.
REQ-040 csWr csD=0 mid-transfer, then reset at half-bit 9 -> cs=0 next clock; after reset cs=1, ck=0, mosi=1, busy=0, q=8'hFF.
